imm_decode_stage: RTL

- Registered decode stage between fetch and execute.
- Extracts rd/rs1/rs2 and the sign-extended immediate for the instruction's encoding type.
- Parametrised in datapath width, with a valid/ready handshake, a two-entry skid buffer, pipeline flush and illegal-encoding detection.
- Successor to the combinational immediate extractor; execute consumes its registered outputs directly.

---
 rtl/imm_decode_stage_pkg.sv | 31 +++
 rtl/imm_decode_stage_imm_select.sv | 57 +++++
 rtl/imm_decode_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - instruction constants shared by the decode stage
//
// Purpose : encoding-type one-hot, default datapath width and the sign
//           extension helper used by the immediate selector.
// Ports   : none (package).

package imm_decode_stage_pkg;

   localparam int unsigned DEFAULT_XLEN = 32;

   // One-hot encoding type; all-zero means R-type (no immediate).
   typedef struct packed {
      logic j;
      logic u;
      logic b;
      logic s;
      logic i;
   } EncodingType;

   // SignExtender: replicate bit 'msb' of 'value' into all higher bits of a
   // 64-bit result. The source is left-aligned and shifted back arithmetically.
   function automatic logic [63:0] sign_extend(input logic [31:0] value,
                                               input logic [4:0]  msb);
      logic [4:0]  shamt;
      logic [63:0] wide;
      shamt = 5'd31 - msb;
      wide  = {value << shamt, 32'b0};
      return $signed(wide) >>> (6'd32 + {1'b0, shamt});
   endfunction

endpackage

// File: rtl/imm_decode_stage_imm_select.sv
// rtl/imm_decode_stage_imm_select.sv - combinational field and immediate extraction
//
// Purpose : pulls rd/rs1/rs2 out of the instruction word, selects the
//           immediate format from the one-hot encoding and sign-extends it
//           to XLEN; multi-hot encodings are flagged illegal with imm = 0.
// Ports   : inst_i     instruction word (bits [6:0] unused)
//           en_i       one-hot encoding type
//           rd_o, rs1_o, rs2_o   register fields
//           imm_o      sign-extended immediate
//           illegal_o  more than one encoding bit set

module imm_select
   import imm_decode_stage_pkg::*;
#(
   parameter int unsigned XLEN = DEFAULT_XLEN
) (
   input  logic [31:0]     inst_i,
   input  EncodingType     en_i,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [XLEN-1:0] imm_o,
   output logic            illegal_o
);

   logic [4:0] en_bits;
   logic       unused_opcode;

   assign en_bits       = en_i;
   assign unused_opcode = ^inst_i[6:0];

   assign rd_o  = inst_i[11:7];
   assign rs1_o = inst_i[19:15];
   assign rs2_o = inst_i[24:20];

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign illegal_o = (en_bits & (en_bits - 5'd1)) != 5'd0;

   always_comb begin
      imm_o = '0;
      if (!illegal_o) begin
         if (en_i.i)
            imm_o = XLEN'(sign_extend({20'b0, inst_i[31:20]}, 5'd11));
         else if (en_i.s)
            imm_o = XLEN'(sign_extend({20'b0, inst_i[31:25], inst_i[11:7]}, 5'd11));
         else if (en_i.b)
            imm_o = XLEN'(sign_extend({19'b0, inst_i[31], inst_i[7], inst_i[30:25],
                                       inst_i[11:8], 1'b0}, 5'd12));
         else if (en_i.u)
            imm_o = XLEN'(sign_extend({inst_i[31:12], 12'b0}, 5'd31));
         else if (en_i.j)
            imm_o = XLEN'(sign_extend({11'b0, inst_i[31], inst_i[19:12], inst_i[20],
                                       inst_i[30:21], 1'b0}, 5'd20));
      end
   end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered decode stage with skid buffer and flush
//
// Purpose : accepts fetched instructions on a valid/ready handshake, decodes
//           them through imm_select and presents registered fields to
//           execute. SKID=1 adds a second entry so in_ready can be a register.
// Ports   : clk, rst_n (async active-low), flush (sync, highest priority)
//           in_valid/in_ready, in_inst, in_en, in_pc   upstream side
//           out_valid/out_ready, out_rd/rs1/rs2, out_imm, out_pc,
//           out_illegal                               downstream side
//           out_target  out_pc + out_imm for B/J, else 0
//                       (present only with IMM_DECODE_TARGET_EN defined)

module imm_decode_stage
   import imm_decode_stage_pkg::*;
#(
   parameter int unsigned XLEN = DEFAULT_XLEN,
   parameter bit          SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  EncodingType     in_en,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
`ifdef IMM_DECODE_TARGET_EN
   output logic [XLEN-1:0] out_target,
`endif
   output logic            out_illegal
);

   typedef struct packed {
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
`ifdef IMM_DECODE_TARGET_EN
      logic [XLEN-1:0] target;
`endif
      logic            illegal;
   } entry_t;

   entry_t          out_q, out_d, skid_q, skid_d, in_entry;
   logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic            in_fire, out_fire;
   logic [4:0]      dec_rd, dec_rs1, dec_rs2;
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   imm_select #(.XLEN(XLEN)) u_imm_select (
      .inst_i    (in_inst),
      .en_i      (in_en),
      .rd_o      (dec_rd),
      .rs1_o     (dec_rs1),
      .rs2_o     (dec_rs2),
      .imm_o     (dec_imm),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      in_entry         = '0;
      in_entry.rd      = dec_rd;
      in_entry.rs1     = dec_rs1;
      in_entry.rs2     = dec_rs2;
      in_entry.imm     = dec_imm;
      in_entry.pc      = in_pc;
      in_entry.illegal = dec_illegal;
`ifdef IMM_DECODE_TARGET_EN
      // Only control-transfer formats carry a meaningful target; wraps mod 2^XLEN.
      if (!dec_illegal && (in_en.b || in_en.j))
         in_entry.target = in_pc + dec_imm;
`endif
   end

   // With a skid entry, ready depends only on a register; without it, ready
   // must look through to out_ready combinationally.
   assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low here, so only the skid-to-output move can happen.
         if (out_fire) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (!out_valid_q || out_fire) begin
         out_valid_d = in_fire;
         if (in_fire)
            out_d = in_entry;
      end else if (in_fire && SKID) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_rd      = out_q.rd;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_imm     = out_q.imm;
   assign out_pc      = out_q.pc;
   assign out_illegal = out_q.illegal;
`ifdef IMM_DECODE_TARGET_EN
   assign out_target  = out_q.target;
`endif

endmodule
